// File: rtl/nvm_channel_pkg.sv
// Shared definitions for the 2 bits/cell NVM channel model: level codes, Q.11 voltages, read FSM states.
// The read FSM gains a SOFT state when VOLTAGE_READ_SOFT_EN is defined.
package nvm_channel_pkg;

    // Level codes; the voltage order is ERASED < S1 < S2 < S3, which is not the numeric order.
    localparam logic [1:0] LVL_ERASED = 2'd0;
    localparam logic [1:0] LVL_S3     = 2'd1;
    localparam logic [1:0] LVL_S1     = 2'd2;
    localparam logic [1:0] LVL_S2     = 2'd3;

    localparam logic signed [15:0] MEAN_ERASED_Q11 = 16'sd2867;
    localparam logic signed [15:0] MEAN_S1_Q11     = 16'sd5222;
    localparam logic signed [15:0] MEAN_S2_Q11     = 16'sd6451;
    localparam logic signed [15:0] MEAN_S3_Q11     = 16'sd7680;

    localparam logic signed [15:0] VREF1_Q11      = 16'sd4506;
    localparam logic signed [15:0] VREF2_Q11      = 16'sd6144;
    localparam logic signed [15:0] VREF3_Q11      = 16'sd7373;
    localparam logic signed [15:0] SOFT_DELTA_Q11 = 16'sd205;

    typedef enum logic [2:0] {
        IDLE,
        S1,
        S2,
        S3,
`ifdef VOLTAGE_READ_SOFT_EN
        SOFT,
`endif
        DONE
    } read_state_t;

    // Hamming weight of a 2-bit error pattern.
    function automatic logic [1:0] bitErrs(input logic [1:0] diff);
        return {diff[1] & diff[0], diff[1] ^ diff[0]};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Statistics counter that adds 0..3 per update and sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              inc_en,
    input  logic [1:0]        inc,
    output logic [DATA_W-1:0] cnt
);

    logic [DATA_W-1:0] count;

    function automatic logic [DATA_W-1:0] satAdd(input logic [DATA_W-1:0] a, input logic [1:0] b);
        logic [DATA_W:0] sum;
        sum = {1'b0, a} + {{(DATA_W-1){1'b0}}, b};
        return sum[DATA_W] ? '1 : sum[DATA_W-1:0];
    endfunction

    // Clear wins over a coincident increment.
    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            count <= '0;
        end else if (inc_en) begin
            count <= satAdd(count, inc);
        end
    end

    assign cnt = count;

endmodule

// File: rtl/voltage_read_detect.sv
// Sequential three-reference read of a programmed cell Vth, level recovery and BER statistics.
// Define VOLTAGE_READ_SOFT_EN to add the SOFT reliability state and the soft_rel output.
module voltage_read_detect
    import nvm_channel_pkg::*;
#(
    parameter logic signed [15:0] VREF1      = VREF1_Q11,
    parameter logic signed [15:0] VREF2      = VREF2_Q11,
    parameter logic signed [15:0] VREF3      = VREF3_Q11,
`ifdef VOLTAGE_READ_SOFT_EN
    parameter logic signed [15:0] SOFT_DELTA = SOFT_DELTA_Q11,
`endif
    parameter int                 CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      vth_word_i,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [1:0]       det_level,
    output logic [1:0]       wr_level,
    output logic             sym_err,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] read_cnt,
    output logic [CNT_W-1:0] sym_err_cnt,
    output logic [CNT_W-1:0] bit_err_cnt
`ifdef VOLTAGE_READ_SOFT_EN
    ,
    output logic             soft_rel
`endif
);

`ifdef VOLTAGE_READ_SOFT_EN
    localparam read_state_t POST_DECIDE = SOFT;
`else
    localparam read_state_t POST_DECIDE = DONE;
`endif

    read_state_t       state, stateNxt;
    logic signed [15:0] vth_r;
    logic [1:0]         lvl_r;
    logic [1:0]         detNxt;
    logic               decide;
    logic               enterDone;
    logic [1:0]         doneDet;
    logic [1:0]         errBits;
    logic               unusedErasedVth;

    // The erased Vth field plays no part in the read decision.
    assign unusedErasedVth = ^vth_word_i[15:2];

    always_comb begin
        stateNxt = state;
        decide   = 1'b0;
        detNxt   = det_level;
        case (state)
            IDLE: begin
                if (in_valid) stateNxt = S1;
            end
            S1: begin
                if (vth_r < VREF1) begin
                    detNxt   = LVL_ERASED;
                    decide   = 1'b1;
                    stateNxt = POST_DECIDE;
                end else begin
                    stateNxt = S2;
                end
            end
            S2: begin
                if (vth_r < VREF2) begin
                    detNxt   = LVL_S1;
                    decide   = 1'b1;
                    stateNxt = POST_DECIDE;
                end else begin
                    stateNxt = S3;
                end
            end
            S3: begin
                detNxt   = (vth_r < VREF3) ? LVL_S2 : LVL_S3;
                decide   = 1'b1;
                stateNxt = POST_DECIDE;
            end
`ifdef VOLTAGE_READ_SOFT_EN
            SOFT: begin
                stateNxt = DONE;
            end
`endif
            DONE: begin
                if (out_ready) stateNxt = IDLE;
            end
            default: stateNxt = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Statistics see the final decision on the very edge that enters DONE.
    assign enterDone = (stateNxt == DONE) && (state != DONE);
    assign doneDet   = decide ? detNxt : det_level;
    assign errBits   = doneDet ^ lvl_r;

    // Capture stage: sampled word held for the whole sense sequence.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            vth_r <= signed'(vth_word_i[31:16]);
            lvl_r <= vth_word_i[1:0];
        end
    end

    // Decision stage: results stay put until the DONE handshake.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            det_level <= LVL_ERASED;
            wr_level  <= 2'd0;
            sym_err   <= 1'b0;
        end else begin
            state <= stateNxt;
            if (decide) begin
                det_level <= detNxt;
                wr_level  <= lvl_r;
                sym_err   <= (detNxt != lvl_r);
            end
        end
    end

`ifdef VOLTAGE_READ_SOFT_EN
    // Reliable when Vth sits at least SOFT_DELTA away from every boundary of its region.
    function automatic logic softRelCalc(input logic signed [15:0] v, input logic [1:0] det);
        logic signed [16:0] vx, r1, r2, r3, dx;
        logic okLo, okHi;
        vx   = {v[15], v};
        r1   = {VREF1[15], VREF1};
        r2   = {VREF2[15], VREF2};
        r3   = {VREF3[15], VREF3};
        dx   = {SOFT_DELTA[15], SOFT_DELTA};
        okLo = 1'b1;
        okHi = 1'b1;
        case (det)
            LVL_ERASED: okHi = (vx <= r1 - dx);
            LVL_S1: begin
                okLo = (vx >= r1 + dx);
                okHi = (vx <= r2 - dx);
            end
            LVL_S2: begin
                okLo = (vx >= r2 + dx);
                okHi = (vx <= r3 - dx);
            end
            default: okLo = (vx >= r3 + dx);
        endcase
        return okLo & okHi;
    endfunction

    // Soft stage: one extra cycle to grade the hard decision.
    always_ff @(posedge clk) begin
        if (!reset) begin
            soft_rel <= 1'b0;
        end else if (state == SOFT) begin
            soft_rel <= softRelCalc(vth_r, det_level);
        end
    end
`endif

    sat_counter #(.DATA_W(CNT_W)) uReadCnt (
        .clk    (clk),
        .reset  (reset),
        .clr    (clr_cnt),
        .inc_en (enterDone),
        .inc    (2'd1),
        .cnt    (read_cnt)
    );

    sat_counter #(.DATA_W(CNT_W)) uSymErrCnt (
        .clk    (clk),
        .reset  (reset),
        .clr    (clr_cnt),
        .inc_en (enterDone),
        .inc    ({1'b0, |errBits}),
        .cnt    (sym_err_cnt)
    );

    sat_counter #(.DATA_W(CNT_W)) uBitErrCnt (
        .clk    (clk),
        .reset  (reset),
        .clr    (clr_cnt),
        .inc_en (enterDone),
        .inc    (bitErrs(errBits)),
        .cnt    (bit_err_cnt)
    );

endmodule
